// File: rtl/abc_sweep_pkg.sv
// Shared types and golden reference for the A/B/C gate-network sweep checker.
// Vector encoding is {A,B,C} = vec[2:0], swept 0..7 with C toggling fastest.
package abc_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam int NUM_VECTORS = 8;
  localparam int VEC_W       = 3;
  localparam int ERR_CNT_W   = 4;

  // Returns {exp_x, exp_y} for one input vector.
  function automatic logic [1:0] golden_xy(input logic [VEC_W-1:0] vec);
    logic a_v;
    logic b_v;
    logic c_v;
    {a_v, b_v, c_v} = vec;
    return {(a_v | b_v) & ~c_v, ~c_v};
  endfunction

endpackage

// File: rtl/abc_sweep_checker_if.sv
// Bundle between the sweep checker and its environment (network + controller).
// master = checker side, slave = network/controller side.
interface abc_sweep_checker_if;
  import abc_sweep_pkg::*;

  logic                 start;
  logic                 a;
  logic                 b;
  logic                 c;
  logic                 x_in;
  logic                 y_in;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [NUM_VECTORS-1:0] err_mask;
  logic [ERR_CNT_W-1:0]   err_count;

  modport master (
    input  start, x_in, y_in,
    output a, b, c, busy, done, pass, err_mask, err_count
  );

  modport slave (
    output start, x_in, y_in,
    input  a, b, c, busy, done, pass, err_mask, err_count
  );

endinterface

// File: rtl/sweep_hold_counter.sv
// Loadable down-counter timing the hold window; o_tc is high while the count is zero.
// Load has priority over decrement; the count saturates at zero.
module sweep_hold_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/abc_sweep_checker.sv
// Drives the 8 A/B/C vectors for HOLD_CYCLES clocks each, samples x/y on the last
// clock of every window and accumulates a mismatch mask, count and pass flag.
module abc_sweep_checker
  import abc_sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 5,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  abc_sweep_checker_if.master  bus
);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [VEC_W-1:0]       r_vec;
  logic [NUM_VECTORS-1:0] r_err_mask;
  logic [ERR_CNT_W-1:0]   r_err_count;
  logic                   r_pass;

  logic                   w_accept;
  logic                   w_tc;
  logic                   w_sample;
  logic                   w_last;
  logic                   w_mismatch;
  logic [1:0]             w_exp_xy;
  logic [ERR_CNT_W-1:0]   w_count_nxt;
  logic                   w_hold_load;

  assign w_accept = (r_state == IDLE) && bus.start;
  assign w_sample = (r_state == RUN) && w_tc;
  assign w_last   = (r_vec == VEC_W'(NUM_VECTORS - 1));

  // The window restarts at every sample edge except the final one, so the
  // counter rests at zero outside a sweep.
  assign w_hold_load = w_accept || (w_sample && !w_last);

  sweep_hold_counter #(
    .W (CNT_W)
  ) u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_hold_load),
    .i_load_val (CNT_W'(HOLD_CYCLES - 1)),
    .i_en       (r_state == RUN),
    .o_tc       (w_tc)
  );

  assign w_exp_xy    = golden_xy(r_vec);
  assign w_mismatch  = w_sample && ({bus.x_in, bus.y_in} != w_exp_xy);
  assign w_count_nxt = r_err_count + (w_mismatch ? ERR_CNT_W'(1) : ERR_CNT_W'(0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = RUN;
      RUN:     if (w_sample && w_last) w_state_nxt = FIN;
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (r_state == RUN);
    bus.done = (r_state == FIN);
  end

  // pass is resolved at the last sample edge with the count that already
  // includes vector 7, so it is valid alongside done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec       <= '0;
      r_err_mask  <= '0;
      r_err_count <= '0;
      r_pass      <= 1'b0;
    end else if (w_accept) begin
      r_vec       <= '0;
      r_err_mask  <= '0;
      r_err_count <= '0;
      r_pass      <= 1'b0;
    end else if (w_sample) begin
      if (w_mismatch) begin
        r_err_mask[r_vec] <= 1'b1;
      end
      r_err_count <= w_count_nxt;
      if (w_last) begin
        r_vec  <= '0;
        r_pass <= (w_count_nxt == '0);
      end else begin
        r_vec  <= r_vec + VEC_W'(1);
      end
    end
  end

  assign bus.a         = r_vec[2];
  assign bus.b         = r_vec[1];
  assign bus.c         = r_vec[0];
  assign bus.err_mask  = r_err_mask;
  assign bus.err_count = r_err_count;
  assign bus.pass      = r_pass;

endmodule

// File: tb/tb_abc_sweep_checker.sv
// Bench for abc_sweep_checker: fault-injectable network model plus a scoreboard of
// expected vectors and sweep results pushed at start and popped as the DUT produces them.
module tb_abc_sweep_checker;

  logic clk;
  logic rst_n;
  int   fault;
  int   n_checks;
  int   n_errs;

  typedef struct packed {
    logic [7:0] mask;
    logic [3:0] cnt;
    logic       pass;
  } res_t;

  logic [2:0] abc_q[$];
  res_t       res_q[$];

  abc_sweep_checker_if bus ();

  abc_sweep_checker #(
    .HOLD_CYCLES (5),
    .CNT_W       (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Network: 0 = correct, 1 = x stuck-at-0, 2 = y follows C.
  always_comb begin
    bus.x_in = (bus.a | bus.b) & ~bus.c;
    bus.y_in = ~bus.c;
    if (fault == 1) bus.x_in = 1'b0;
    if (fault == 2) bus.y_in = bus.c;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] net_xy(input int fm, input logic [2:0] v);
    logic x;
    logic y;
    x = (v[2] | v[1]) & ~v[0];
    y = ~v[0];
    if (fm == 1) x = 1'b0;
    if (fm == 2) y = v[0];
    return {x, y};
  endfunction

  function automatic logic [1:0] ref_xy(input logic [2:0] v);
    return {(v[2] | v[1]) & ~v[0], ~v[0]};
  endfunction

  task automatic push_expect(input int fm);
    res_t r;
    r = '0;
    for (int v = 0; v < 8; v++) begin
      abc_q.push_back(3'(v));
      if (net_xy(fm, 3'(v)) != ref_xy(3'(v))) begin
        r.mask[v] = 1'b1;
        r.cnt     = r.cnt + 4'd1;
      end
    end
    r.pass = (r.cnt == 4'd0);
    res_q.push_back(r);
  endtask

  // Returns at the negedge right after the accepting edge E0.
  task automatic drive_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_sweep(input int fm, input bit extra);
    int   done_m;
    int   done_cnt;
    res_t r;
    logic [2:0] e_abc;
    fault = fm;
    push_expect(fm);
    drive_start();
    done_m   = -1;
    done_cnt = 0;
    for (int m = 0; m < 60; m++) begin
      if (m > 0) @(negedge clk);
      if (m == 0) begin
        chk("start_mask_clr", 32'(bus.err_mask), 32'h00);
        chk("start_cnt_clr", 32'(bus.err_count), 32'd0);
        chk("start_pass_clr", 32'(bus.pass), 32'd0);
      end
      if ((m % 5 == 0) && (m < 40)) begin
        chk("busy_run", 32'(bus.busy), 32'd1);
        if (abc_q.size() > 0) begin
          e_abc = abc_q.pop_front();
          chk("abc_vec", 32'({bus.a, bus.b, bus.c}), 32'(e_abc));
        end else begin
          chk("abc_q_underflow", 32'd1, 32'd0);
        end
      end
      if (m == 45) chk("busy_after", 32'(bus.busy), 32'd0);
      if (bus.done) begin
        done_cnt++;
        if (done_m < 0) begin
          done_m = m;
          chk("done_abc", 32'({bus.a, bus.b, bus.c}), 32'd0);
          chk("done_busy", 32'(bus.busy), 32'd0);
          if (res_q.size() > 0) begin
            r = res_q.pop_front();
            chk("err_mask", 32'(bus.err_mask), 32'(r.mask));
            chk("err_count", 32'(bus.err_count), 32'(r.cnt));
            chk("pass", 32'(bus.pass), 32'(r.pass));
          end
        end
      end
      bus.start = extra && ((m == 11) || (m == 39));
    end
    bus.start = 1'b0;
    chk("done_time", 32'(done_m), 32'd40);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("res_q_empty", 32'(res_q.size()), 32'd0);
    r = '0;
    if (res_q.size() == 0) r.mask = bus.err_mask;
    chk("mask_hold", 32'(r.mask), 32'(bus.err_mask));
  endtask

  task automatic reset_mid_sweep();
    fault = 1;
    push_expect(1);
    drive_start();
    repeat (17) @(negedge clk);
    chk("pre_rst_abc", 32'({bus.a, bus.b, bus.c}), 32'd3);
    chk("pre_rst_mask", 32'(bus.err_mask), 32'h04);
    rst_n = 1'b0;
    #1;
    chk("rst_abc", 32'({bus.a, bus.b, bus.c}), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_mask", 32'(bus.err_mask), 32'h00);
    chk("rst_cnt", 32'(bus.err_count), 32'd0);
    abc_q.delete();
    res_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(0, 1'b0);
  endtask

  initial begin
    n_checks  = 0;
    n_errs    = 0;
    fault     = 0;
    bus.start = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_abc", 32'({bus.a, bus.b, bus.c}), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_pass", 32'(bus.pass), 32'd0);
    chk("reset_mask", 32'(bus.err_mask), 32'h00);
    chk("reset_cnt", 32'(bus.err_count), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_sweep(0, 1'b0);
    run_sweep(1, 1'b0);
    run_sweep(2, 1'b0);
    reset_mid_sweep();
    run_sweep(0, 1'b1);
    run_sweep(1, 1'b0);
    run_sweep(0, 1'b0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
